// File: rtl/mcu51_pkg.sv
// rtl/mcu51_pkg.sv - shared 8051 decode constants, ALU codes and decode record
//
// Purpose: process-type codes, ALU function codes, opcode constants and the
// packed decode record produced by ins_decode_rom and consumed by ins_decode.
// Ports: none (package).
package mcu51_pkg;

    localparam logic [1:0] PT_WAITE    = 2'd0;
    localparam logic [1:0] PT_ALU_CAL  = 2'd1;
    localparam logic [1:0] PT_MOV      = 2'd2;
    localparam logic [1:0] PT_CODE_CON = 2'd3;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_ADDC = 5'd1;
    localparam logic [4:0] ALU_SUBB = 5'd2;
    localparam logic [4:0] ALU_ANL  = 5'd3;
    localparam logic [4:0] ALU_ORL  = 5'd4;
    localparam logic [4:0] ALU_XRL  = 5'd5;
    localparam logic [4:0] ALU_INC  = 5'd6;
    localparam logic [4:0] ALU_DEC  = 5'd7;
    localparam logic [4:0] ALU_CPL  = 5'd8;
    localparam logic [4:0] ALU_CLR  = 5'd9;
    localparam logic [4:0] ALU_RL   = 5'd10;
    localparam logic [4:0] ALU_RR   = 5'd11;
    localparam logic [4:0] ALU_RLC  = 5'd12;
    localparam logic [4:0] ALU_RRC  = 5'd13;
    localparam logic [4:0] ALU_SWAP = 5'd14;
    localparam logic [4:0] ALU_MUL  = 5'd15;
    localparam logic [4:0] ALU_DIV  = 5'd16;
    localparam logic [4:0] ALU_DA   = 5'd17;

    localparam logic [7:0] OPC_NOP   = 8'h00;
    localparam logic [7:0] OPC_ADD   = 8'h24;
    localparam logic [7:0] OPC_ADDC  = 8'h34;
    localparam logic [7:0] OPC_SUBB  = 8'h94;
    localparam logic [7:0] OPC_ANL   = 8'h54;
    localparam logic [7:0] OPC_ORL   = 8'h44;
    localparam logic [7:0] OPC_XRL   = 8'h64;
    localparam logic [7:0] OPC_INC   = 8'h04;
    localparam logic [7:0] OPC_DEC   = 8'h14;
    localparam logic [7:0] OPC_CPL   = 8'hF4;
    localparam logic [7:0] OPC_CLR   = 8'hE4;
    localparam logic [7:0] OPC_RL    = 8'h23;
    localparam logic [7:0] OPC_RR    = 8'h03;
    localparam logic [7:0] OPC_RLC   = 8'h33;
    localparam logic [7:0] OPC_RRC   = 8'h13;
    localparam logic [7:0] OPC_SWAP  = 8'hC4;
    localparam logic [7:0] OPC_DA    = 8'hD4;
    localparam logic [7:0] OPC_MUL   = 8'hA4;
    localparam logic [7:0] OPC_DIV   = 8'h84;
    localparam logic [7:0] OPC_MOVI  = 8'h74;
    localparam logic [7:0] OPC_SJMP  = 8'h80;
    localparam logic [7:0] OPC_LJMP  = 8'h02;

    typedef struct packed {
        logic [1:0] ptype;
        logic       alu_en;
        logic [4:0] alu_op;
        logic [1:0] len;      // total instruction length in bytes (1..3)
        logic       illegal;
    } dec_rec_t;

    localparam dec_rec_t REC_ILLEGAL = '{ptype: PT_WAITE, alu_en: 1'b0, alu_op: 5'd0,
                                         len: 2'd1, illegal: 1'b1};

    function automatic dec_rec_t plain_rec(input logic [1:0] ptype, input logic [1:0] len);
        return '{ptype: ptype, alu_en: 1'b0, alu_op: 5'd0, len: len, illegal: 1'b0};
    endfunction

    function automatic dec_rec_t alu_rec(input logic [4:0] op, input logic [1:0] len);
        return '{ptype: PT_ALU_CAL, alu_en: 1'b1, alu_op: op, len: len, illegal: 1'b0};
    endfunction

endpackage

// File: rtl/ins_decode_rom.sv
// rtl/ins_decode_rom.sv - combinational opcode to decode-record lookup
//
// Purpose: maps an 8051 opcode byte onto a dec_rec_t. Unknown opcodes give
// REC_ILLEGAL (1-byte, WAITE, illegal=1). MUL/DIV decode only when the
// MULDIV_EN macro is defined; otherwise they fall through to illegal.
// Ports:
//   opcode  in   8-bit opcode byte
//   rec     out  decoded record {ptype, alu_en, alu_op, len, illegal}
module ins_decode_rom
    import mcu51_pkg::*;
(
    input  logic [7:0] opcode,
    output dec_rec_t   rec
);

    always_comb begin
        rec = REC_ILLEGAL;
        case (opcode)
            OPC_NOP:  rec = plain_rec(PT_WAITE, 2'd1);
            OPC_ADD:  rec = alu_rec(ALU_ADD,  2'd2);
            OPC_ADDC: rec = alu_rec(ALU_ADDC, 2'd2);
            OPC_SUBB: rec = alu_rec(ALU_SUBB, 2'd2);
            OPC_ANL:  rec = alu_rec(ALU_ANL,  2'd2);
            OPC_ORL:  rec = alu_rec(ALU_ORL,  2'd2);
            OPC_XRL:  rec = alu_rec(ALU_XRL,  2'd2);
            OPC_INC:  rec = alu_rec(ALU_INC,  2'd1);
            OPC_DEC:  rec = alu_rec(ALU_DEC,  2'd1);
            OPC_CPL:  rec = alu_rec(ALU_CPL,  2'd1);
            OPC_CLR:  rec = alu_rec(ALU_CLR,  2'd1);
            OPC_RL:   rec = alu_rec(ALU_RL,   2'd1);
            OPC_RR:   rec = alu_rec(ALU_RR,   2'd1);
            OPC_RLC:  rec = alu_rec(ALU_RLC,  2'd1);
            OPC_RRC:  rec = alu_rec(ALU_RRC,  2'd1);
            OPC_SWAP: rec = alu_rec(ALU_SWAP, 2'd1);
            OPC_DA:   rec = alu_rec(ALU_DA,   2'd1);
`ifdef MULDIV_EN
            OPC_MUL:  rec = alu_rec(ALU_MUL,  2'd1);
            OPC_DIV:  rec = alu_rec(ALU_DIV,  2'd1);
`endif
            OPC_MOVI: rec = plain_rec(PT_MOV,      2'd2);
            OPC_SJMP: rec = plain_rec(PT_CODE_CON, 2'd2);
            OPC_LJMP: rec = plain_rec(PT_CODE_CON, 2'd3);
            default:  rec = REC_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/ins_decode.sv
// rtl/ins_decode.sv - 8051 instruction-decode stage (opcode + operand collection)
//
// Purpose: accepts opcode/operand bytes from fetch, decodes via ins_decode_rom,
// collects 1-2 operand bytes and issues a registered decoded bundle, marked by
// a 0->1 edge on id_ready. Optional MUL/DIV decode under macro MULDIV_EN.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   ins_valid     fetch presents ins_byte
//   ins_byte      opcode or operand byte
//   ins_ready     byte taken when ins_valid & ins_ready (combinational)
//   pro_ready     processing stage idle; gates opcode acceptance only
//   id_ready      0 while decoding; rises when a new bundle is issued
//   process_type, alu_en, alu_op, op1, op2, illegal   decoded bundle
module ins_decode
    import mcu51_pkg::*;
#(
    parameter int IMM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ins_valid,
    input  logic [IMM_W-1:0] ins_byte,
    output logic             ins_ready,
    input  logic             pro_ready,
    output logic             id_ready,
    output logic [1:0]       process_type,
    output logic             alu_en,
    output logic [4:0]       alu_op,
    output logic [IMM_W-1:0] op1,
    output logic [IMM_W-1:0] op2,
    output logic             illegal
);

    typedef enum logic [1:0] {S_OP, S_B2, S_B3, S_ISSUE} state_t;

    state_t           state, state_nxt;
    dec_rec_t         rom_rec;
    dec_rec_t         rec_q;
    logic [IMM_W-1:0] opnd1_q, opnd2_q;
    logic             accept;

    ins_decode_rom u_rom (
        .opcode (ins_byte[7:0]),
        .rec    (rom_rec)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= S_OP;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ins_ready = 1'b0;
        case (state)
            S_OP: begin
                ins_ready = pro_ready;
                if (ins_valid && pro_ready)
                    state_nxt = (rom_rec.len >= 2'd2) ? S_B2 : S_ISSUE;
            end
            S_B2: begin
                ins_ready = 1'b1;
                if (ins_valid)
                    state_nxt = (rec_q.len == 2'd3) ? S_B3 : S_ISSUE;
            end
            S_B3: begin
                ins_ready = 1'b1;
                if (ins_valid) state_nxt = S_ISSUE;
            end
            S_ISSUE: state_nxt = S_OP;
            default: state_nxt = S_OP;
        endcase
        if (rst) ins_ready = 1'b0;
    end

    assign accept = ins_valid & ins_ready;

    // Operands are gathered in private registers so the visible bundle only
    // moves on the issue edge and stays stable while id_ready is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_q        <= '0;
            opnd1_q      <= '0;
            opnd2_q      <= '0;
            id_ready     <= 1'b1;
            process_type <= PT_WAITE;
            alu_en       <= 1'b0;
            alu_op       <= 5'd0;
            op1          <= '0;
            op2          <= '0;
            illegal      <= 1'b0;
        end else begin
            case (state)
                S_OP: if (accept) begin
                    rec_q    <= rom_rec;
                    opnd1_q  <= '0;
                    opnd2_q  <= '0;
                    id_ready <= 1'b0;
                end
                S_B2: if (accept) opnd1_q <= ins_byte;
                S_B3: if (accept) opnd2_q <= ins_byte;
                S_ISSUE: begin
                    id_ready     <= 1'b1;
                    process_type <= rec_q.ptype;
                    alu_en       <= rec_q.alu_en;
                    alu_op       <= rec_q.alu_op;
                    op1          <= opnd1_q;
                    op2          <= opnd2_q;
                    illegal      <= rec_q.illegal;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ins_decode.sv
// tb/tb_ins_decode.sv - self-checking bench for ins_decode (directed + random)
module tb_ins_decode;

    localparam int IMM_W = 8;
`ifdef MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             ins_valid;
    logic [IMM_W-1:0] ins_byte;
    logic             ins_ready;
    logic             pro_ready;
    logic             id_ready;
    logic [1:0]       process_type;
    logic             alu_en;
    logic [4:0]       alu_op;
    logic [IMM_W-1:0] op1;
    logic [IMM_W-1:0] op2;
    logic             illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ins_decode #(.IMM_W(IMM_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .ins_valid    (ins_valid),
        .ins_byte     (ins_byte),
        .ins_ready    (ins_ready),
        .pro_ready    (pro_ready),
        .id_ready     (id_ready),
        .process_type (process_type),
        .alu_en       (alu_en),
        .alu_op       (alu_op),
        .op1          (op1),
        .op2          (op2),
        .illegal      (illegal)
    );

    // opcode, process type, alu op, length, needs MUL/DIV option
    int tbl [22][5] = '{
        '{'h00, 0,  0, 1, 0},
        '{'h24, 1,  0, 2, 0}, '{'h34, 1,  1, 2, 0}, '{'h94, 1,  2, 2, 0},
        '{'h54, 1,  3, 2, 0}, '{'h44, 1,  4, 2, 0}, '{'h64, 1,  5, 2, 0},
        '{'h04, 1,  6, 1, 0}, '{'h14, 1,  7, 1, 0}, '{'hF4, 1,  8, 1, 0},
        '{'hE4, 1,  9, 1, 0}, '{'h23, 1, 10, 1, 0}, '{'h03, 1, 11, 1, 0},
        '{'h33, 1, 12, 1, 0}, '{'h13, 1, 13, 1, 0}, '{'hC4, 1, 14, 1, 0},
        '{'hD4, 1, 17, 1, 0},
        '{'hA4, 1, 15, 1, 1}, '{'h84, 1, 16, 1, 1},
        '{'h74, 2,  0, 2, 0}, '{'h80, 3,  0, 2, 0}, '{'h02, 3,  0, 3, 0}
    };

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic ref_decode(input logic [7:0] opc, output int ptype, output int aop,
                              output int len, output int ill);
        ptype = 0; aop = 0; len = 1; ill = 1;
        for (int i = 0; i < 22; i++) begin
            if (tbl[i][0] == int'(opc) && (tbl[i][4] == 0 || MULDIV)) begin
                ptype = tbl[i][1]; aop = tbl[i][2]; len = tbl[i][3]; ill = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte (after an optional idle gap) until the handshake completes.
    task automatic send(input logic [7:0] b, input int gap, input bit busy);
        logic acc;
        int   guard;
        ins_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            tick();
            if (busy) check("id_ready_low_in_gap", id_ready, 0);
        end
        ins_valid = 1'b1;
        ins_byte  = b;
        acc   = 1'b0;
        guard = 0;
        while (!acc && guard < 40) begin
            #1;
            acc = ins_ready;
            tick();
            guard++;
        end
        if (!acc) check("accept_timeout", 0, 1);
        ins_valid = 1'b0;
    endtask

    task automatic run_ins(input logic [7:0] opc, input logic [7:0] b1, input logic [7:0] b2,
                           input int gap, input int hold_pr);
        int ept, eop, elen, eill, guard;
        ref_decode(opc, ept, eop, elen, eill);
        if (hold_pr > 0) begin
            pro_ready = 1'b0;
            ins_valid = 1'b1;
            ins_byte  = opc;
            for (int i = 0; i < hold_pr; i++) begin
                #1;
                check("ins_ready_blocked", ins_ready, 0);
                tick();
                check("id_ready_held", id_ready, 1);
            end
        end
        pro_ready = 1'b1;
        send(opc, 0, 1'b0);
        check("id_ready_after_opcode", id_ready, 0);
        if (elen >= 2) begin
            pro_ready = 1'($urandom);
            send(b1, gap, 1'b1);
        end
        if (elen == 3) begin
            pro_ready = 1'($urandom);
            send(b2, gap, 1'b1);
        end
        pro_ready = 1'b1;
        guard = 0;
        while (id_ready !== 1'b1 && guard < 10) begin
            tick();
            guard++;
        end
        check("issue_latency", guard, 1);
        check("process_type", process_type, ept);
        check("alu_en", alu_en, (ept == 1) ? 1 : 0);
        check("alu_op", alu_op, eop);
        check("op1", op1, (elen >= 2) ? b1 : 8'h00);
        check("op2", op2, (elen == 3) ? b2 : 8'h00);
        check("illegal", illegal, eill);
        tick();
        check("hold_process_type", process_type, ept);
        check("hold_op1", op1, (elen >= 2) ? b1 : 8'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] r_opc, r_b1, r_b2;
        int         idx;

        rst = 1'b1; ins_valid = 1'b0; ins_byte = 8'h00; pro_ready = 1'b1;
        tick();
        #1;
        check("ins_ready_in_reset", ins_ready, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rst_id_ready", id_ready, 1);
        check("rst_process_type", process_type, 0);
        check("rst_alu_en", alu_en, 0);
        check("rst_alu_op", alu_op, 0);
        check("rst_op1", op1, 0);
        check("rst_op2", op2, 0);
        check("rst_illegal", illegal, 0);

        // ADD #imm back to back: id_ready 1,0,0,1
        run_ins(8'h24, 8'h5A, 8'h00, 0, 0);
        check("add_alu_op", alu_op, 0);
        check("add_op1", op1, 8'h5A);

        // LJMP with 2-cycle gaps
        run_ins(8'h02, 8'h12, 8'h34, 2, 0);
        check("ljmp_type", process_type, 3);
        check("ljmp_op2", op2, 8'h34);

        // INC offered while pro_ready is low
        run_ins(8'h04, 8'h00, 8'h00, 0, 3);
        check("inc_alu_op", alu_op, 6);

        // Illegal, then NOP, then MUL
        run_ins(8'hA5, 8'h00, 8'h00, 0, 0);
        check("illegal_flag", illegal, 1);
        run_ins(8'h00, 8'h00, 8'h00, 0, 0);
        check("nop_illegal_cleared", illegal, 0);
        run_ins(8'hA4, 8'h00, 8'h00, 0, 0);
`ifdef MULDIV_EN
        check("mul_alu_op", alu_op, 15);
`else
        check("mul_illegal", illegal, 1);
`endif

        // Reset in the middle of MOV A,#imm
        pro_ready = 1'b1;
        send(8'h74, 0, 1'b0);
        check("mov_id_ready_busy", id_ready, 0);
        rst = 1'b1;
        tick();
        check("midrst_id_ready", id_ready, 1);
        check("midrst_process_type", process_type, 0);
        check("midrst_alu_op", alu_op, 0);
        check("midrst_illegal", illegal, 0);
        #1;
        check("midrst_ins_ready", ins_ready, 0);
        rst = 1'b0;
        tick();
        check("midrst_no_mov", process_type, 0);
        run_ins(8'hE4, 8'h00, 8'h00, 0, 0);
        check("clr_alu_op", alu_op, 9);
        check("clr_op1", op1, 0);

        // Randomised instruction stream
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 9) < 7) begin
                idx   = int'($urandom_range(0, 21));
                r_opc = 8'(tbl[idx][0]);
            end else begin
                r_opc = 8'($urandom);
            end
            r_b1 = 8'($urandom);
            r_b2 = 8'($urandom);
            run_ins(r_opc, r_b1, r_b2, int'($urandom_range(0, 2)),
                    ($urandom_range(0, 3) == 3) ? int'($urandom_range(1, 3)) : 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ins_decode.md
Name: ins_decode

Overview:
Instruction-decode stage sitting directly upstream of the instruction-processing stage (ALU / move / code-control dispatch). Accepts opcode and operand bytes from the fetch stage over a valid/ready handshake, decodes a defined 8051 subset, and collects 1–2 operand bytes. Presents a stable decoded bundle (process_type, alu_en, alu_op, operands) and marks each new instruction with a rising edge on id_ready. Accepts a new opcode only while the processing stage reports pro_ready=1.

Parameters:
IMM_W, 8, operand byte width (fixed 8 for 8051; parameterised for bench reuse)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
ins_valid  input  1  fetch presents a byte on ins_byte
ins_byte  input  8  opcode or operand byte
ins_ready  output  1  byte accepted on the cycle where ins_valid & ins_ready
pro_ready  input  1  processing stage idle; gates opcode acceptance
id_ready  output  1  0 while decoding; 0→1 edge marks a new decoded instruction
process_type  output  2  0 WAITE, 1 ALU_CAL, 2 MOV, 3 CODE_CON
alu_en  output  1  1 when process_type = ALU_CAL
alu_op  output  5  ALU function code
op1  output  8  first operand byte (immediate / rel / addr_hi)
op2  output  8  second operand byte (addr_lo for LJMP)
illegal  output  1  1 with the bundle of an undecodable opcode

Behaviour:
- All outputs registered except ins_ready (combinational from state, pro_ready, rst).
- Reset values: id_ready=1, process_type=0, alu_en=0, alu_op=0, op1=0, op2=0, illegal=0, state=S_OP; ins_ready=0 while rst=1.
- States: S_OP, S_B2, S_B3, S_ISSUE.
- S_OP: ins_ready=pro_ready. On accept: latch opcode, decode, clear op1/op2, id_ready←0; go to S_B2 if length≥2, else S_ISSUE.
- S_B2: ins_ready=1. On accept: op1←byte; go to S_B3 if length=3, else S_ISSUE. Without accept, wait indefinitely; id_ready stays 0.
- S_B3: ins_ready=1. On accept: op2←byte; go to S_ISSUE.
- S_ISSUE: ins_ready=0. id_ready←1, drive decoded bundle; go to S_OP.
- Latency: 1-byte instr accepted at edge N → id_ready=0 after N, 1 after N+1. Each extra byte adds ≥1 cycle.
- Bundle (process_type, alu_en, alu_op, op1, op2, illegal) changes only on the S_ISSUE edge. It stays stable while id_ready=1, until the next S_ISSUE.
- Decode table (opcode → type/op/length):
  - 0x00 NOP → WAITE/1
  - 0x24 ADD#0, 0x34 ADDC#1, 0x94 SUBB#2, 0x54 ANL#3, 0x44 ORL#4, 0x64 XRL#5 → ALU/2
  - 0x04 INC6, 0x14 DEC7, 0xF4 CPL8, 0xE4 CLR9, 0x23 RL10, 0x03 RR11, 0x33 RLC12, 0x13 RRC13, 0xC4 SWAP14, 0xD4 DA17 → ALU/1
  - 0xA4 MUL15, 0x84 DIV16 → ALU/1 (see option)
  - 0x74 MOV A,#imm → MOV/2
  - 0x80 SJMP rel → CODE_CON/2
  - 0x02 LJMP addr16 → CODE_CON/3
- Illegal opcode: length 1, process_type=WAITE, alu_en=0, alu_op=0, illegal=1 for that bundle only; cleared at next S_ISSUE.
- alu_op=0 whenever alu_en=0.
- pro_ready low in S_OP: no accept, state held. pro_ready ignored in S_B2/S_B3.
- rst mid-instruction: partial bytes discarded, all reset values restored next edge.

Optional Feature:
MULDIV_EN – defined: 0xA4/0x84 decode as ALU_CAL with alu_op 15/16. Undefined: both decode as illegal (WAITE, illegal=1), and op codes 15/16 are never emitted.

Decomposition:
- Shared package mcu51_pkg:
  - process_type constants WAITE/ALU_CAL/MOV/CODE_CON
  - ALU_* op codes 0–17
  - opcode constants
  - decode-record typedef {ptype, alu_en, alu_op, len[1:0], illegal}
- Sub-module ins_decode_rom: combinational opcode→record lookup containing the MULDIV_EN conditional. ins_decode holds the FSM and registers.

Test Plan:
- Reset held 2 cycles, then released with ins_valid=0 → id_ready=1, all bundle outputs 0, state idle.
- pro_ready=1, feed 0x24 then 0x5A back-to-back → id_ready 1,0,0,1; process_type=1, alu_en=1, alu_op=0, op1=0x5A.
- Feed 0x02,0x12,0x34 with 2-cycle gaps on ins_valid → id_ready low throughout; then CODE_CON, op1=0x12, op2=0x34, alu_en=0.
- pro_ready=0 while 0x04 offered → ins_ready=0, no state change; raise pro_ready → accept; next bundle ALU, alu_op=6, id_ready edge.
- Feed 0xA5 → illegal=1, process_type=0; then 0x00 → illegal=0, WAITE. Feed 0xA4: with MULDIV_EN → alu_op=15; without → illegal=1.
- Feed 0x74, assert rst before operand, release, feed 0xE4 → no MOV bundle issued; ALU alu_op=9, op1=0.
